// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard controller FSM encoding, timeout default and
// the load-use hazard predicate.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hz_state_t;

  localparam int MAX_WAIT_DEFAULT = 15;
  localparam int WAIT_W           = 8;

  // r0 is hard-wired to zero, so a load targeting it never creates a hazard.
  function automatic logic load_use_hit(input logic       ex_mem_ren,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt,
                                        input logic       id_uses_rt);
    return ex_mem_ren && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  // No handshake: the master presents pipeline status every cycle and the
  // slave returns combinational controls for that same cycle plus counters.
  logic [4:0]       ID_RS;
  logic [4:0]       ID_RT;
  logic             ID_uses_RT;
  logic             EX_MEM_REN;
  logic [4:0]       EX_RT;
  logic             ID_PC_jump;
  logic             EX_branch_taken;
  logic             mem_busy;
  logic             clear_err;
  logic             PC_WEN;
  logic             IF_ID_WEN;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic             pipe_hold;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_RS, ID_RT, ID_uses_RT, EX_MEM_REN, EX_RT, ID_PC_jump,
           EX_branch_taken, mem_busy, clear_err,
    input  PC_WEN, IF_ID_WEN, IF_ID_flush, ID_EX_bubble, pipe_hold,
           mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  ID_RS, ID_RT, ID_uses_RT, EX_MEM_REN, EX_RT, ID_PC_jump,
           EX_branch_taken, mem_busy, clear_err,
    output PC_WEN, IF_ID_WEN, IF_ID_flush, ID_EX_bubble, pipe_hold,
           mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, memory
// wait freeze with timeout, and saturating stall/flush performance counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.slave  hz,
  output hz_state_t     dbg_state
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              pc_wen, if_id_wen, if_id_flush, id_ex_bubble;
  logic              pipe_hold, mem_timeout, load_use;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  assign load_use = load_use_hit(hz.EX_MEM_REN, hz.EX_RT, hz.ID_RS, hz.ID_RT,
                                 hz.ID_uses_RT);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_wen       = 1'b1;
    if_id_wen    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    mem_timeout  = 1'b0;
    case (state_q)
      TIMEOUT: begin
        pc_wen      = 1'b0;
        if_id_wen   = 1'b0;
        pipe_hold   = 1'b1;
        mem_timeout = 1'b1;
        if (hz.clear_err) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        if (hz.mem_busy) begin
          pc_wen     = 1'b0;
          if_id_wen  = 1'b0;
          pipe_hold  = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          state_d    = (wait_cnt_q == WAIT_LAST) ? TIMEOUT : MEM_WAIT;
        end else begin
          wait_cnt_d = '0;
          state_d    = RUN;
          // Taken branch squashes the ID instruction, so its hazard is moot.
          if (hz.EX_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_wen       = 1'b0;
            if_id_wen    = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (hz.ID_PC_jump) begin
            if_id_flush  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (!pc_wen),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (if_id_flush),
    .count (flush_cnt)
  );

  assign hz.PC_WEN       = pc_wen;
  assign hz.IF_ID_WEN    = if_id_wen;
  assign hz.IF_ID_flush  = if_id_flush;
  assign hz.ID_EX_bubble = id_ex_bubble;
  assign hz.pipe_hold    = pipe_hold;
  assign hz.mem_timeout  = mem_timeout;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_count  = flush_cnt;
  assign dbg_state       = state_q;

endmodule
